lpif_link_bringup_ctrl: RTL and testbench



---
 rtl/lpif_link_bringup_ctrl.sv | 146 ++++++++++++++
 tb/tb_lpif_link_bringup_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lpif_link_bringup_ctrl.sv
// LPIF link bring-up sequencer: PHY debounce, tx/rx online
// sequencing, alignment timeout with bounded retry.
module lpif_link_bringup_ctrl #(
  parameter int STABLE_CYCLES = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic                             clk_wr,
  input  logic                             rst_wr_n,
  input  logic                             enable,
  input  logic                             phy_tx_ready,
  input  logic                             phy_rx_ready,
  input  logic                             align_done,
  input  logic [15:0]                      align_timeout,
  input  logic [15:0]                      settle_cycles,
  output logic                             tx_online,
  output logic                             rx_online,
  output logic                             link_up,
  output logic                             link_drop,
  output logic                             timeout_err,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
  output logic [2:0]                       ctrl_state
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PHY = 3'd1,
    S_TX_ON    = 3'd2,
    S_RX_ON    = 3'd3,
    S_LINK_UP  = 3'd4,
    S_ERR      = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [RW-1:0]   retry_inc;
  logic            drop_d;
  logic            phy_ok;
  logic            online;
  logic            tx_q, rx_q, up_q, drop_q, err_q;

  assign phy_ok    = phy_tx_ready & phy_rx_ready;
  assign retry_inc = retry_q + 1'b1;
  assign online    = (state_q == S_TX_ON) || (state_q == S_RX_ON) ||
                     (state_q == S_LINK_UP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    retry_d = retry_q;
    drop_d  = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      timer_d = '0;
      retry_d = '0;
    end else if (online && !phy_ok) begin
      state_d = S_WAIT_PHY;
      cnt_d   = '0;
      drop_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_PHY;
          cnt_d   = '0;
          timer_d = '0;
          retry_d = '0;
        end
        S_WAIT_PHY: begin
          if (cnt_q == STABLE_MAX) begin
            state_d = S_TX_ON;
            timer_d = align_timeout;
          end else if (phy_ok) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
          end
        end
        S_TX_ON: begin
          if (align_done) begin
            state_d = S_RX_ON;
            timer_d = settle_cycles;
          end else if (align_timeout != 16'd0) begin
            // a timer of 1 is the last cycle of the alignment window
            if (timer_q == 16'd1) begin
              retry_d = retry_inc;
              timer_d = '0;
              cnt_d   = '0;
              state_d = (retry_inc == RETRY_MAX) ? S_ERR : S_WAIT_PHY;
            end else if (timer_q != 16'd0) begin
              timer_d = timer_q - 16'd1;
            end
          end
        end
        S_RX_ON: begin
          if (timer_q != 16'd0) timer_d = timer_q - 16'd1;
          if (timer_q <= 16'd1) state_d = S_LINK_UP;
        end
        S_LINK_UP: ;
        S_ERR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      retry_q <= '0;
      tx_q    <= 1'b0;
      rx_q    <= 1'b0;
      up_q    <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      tx_q    <= (state_d == S_TX_ON) || (state_d == S_RX_ON) ||
                 (state_d == S_LINK_UP);
      rx_q    <= (state_d == S_RX_ON) || (state_d == S_LINK_UP);
      up_q    <= (state_d == S_LINK_UP);
      drop_q  <= drop_d;
      err_q   <= (state_d == S_ERR);
    end
  end

  assign tx_online   = tx_q;
  assign rx_online   = rx_q;
  assign link_up     = up_q;
  assign link_drop   = drop_q;
  assign timeout_err = err_q;
  assign retry_cnt   = retry_q;
  assign ctrl_state  = state_q;

endmodule

// File: tb/tb_lpif_link_bringup_ctrl.sv
// Bench for lpif_link_bringup_ctrl: directed scenarios plus
// randomized traffic against a phase/dwell reference model.
module tb_lpif_link_bringup_ctrl;

  localparam int S  = 8;
  localparam int MR = 3;

  logic        clk_wr;
  logic        rst_wr_n;
  logic        enable;
  logic        phy_tx_ready;
  logic        phy_rx_ready;
  logic        align_done;
  logic [15:0] align_timeout;
  logic [15:0] settle_cycles;
  logic        tx_online;
  logic        rx_online;
  logic        link_up;
  logic        link_drop;
  logic        timeout_err;
  logic [1:0]  retry_cnt;
  logic [2:0]  ctrl_state;

  lpif_link_bringup_ctrl #(
    .STABLE_CYCLES(S),
    .MAX_RETRY    (MR)
  ) dut (
    .clk_wr       (clk_wr),
    .rst_wr_n     (rst_wr_n),
    .enable       (enable),
    .phy_tx_ready (phy_tx_ready),
    .phy_rx_ready (phy_rx_ready),
    .align_done   (align_done),
    .align_timeout(align_timeout),
    .settle_cycles(settle_cycles),
    .tx_online    (tx_online),
    .rx_online    (rx_online),
    .link_up      (link_up),
    .link_drop    (link_drop),
    .timeout_err  (timeout_err),
    .retry_cnt    (retry_cnt),
    .ctrl_state   (ctrl_state)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: phase, consecutive-ready run, cycles in phase
  int m_ph, m_run, m_dwell, m_retry, m_win, m_settle;
  bit m_drop;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_ph = 0; m_run = 0; m_dwell = 0; m_retry = 0;
    m_win = 0; m_settle = 1; m_drop = 0;
  endfunction

  function automatic void m_step(bit en, bit rdy, bit ad);
    m_drop = 0;
    if (!en) begin
      m_ph = 0; m_retry = 0; m_run = 0; m_dwell = 0;
    end else if (m_ph >= 2 && m_ph <= 4 && !rdy) begin
      m_ph = 1; m_drop = 1; m_run = 0;
    end else if (m_ph == 0) begin
      m_ph = 1; m_run = 0;
    end else if (m_ph == 1) begin
      if (m_run >= S) begin
        m_ph = 2; m_dwell = 0; m_win = int'(align_timeout);
      end else begin
        m_run = rdy ? m_run + 1 : 0;
      end
    end else if (m_ph == 2) begin
      m_dwell++;
      if (ad) begin
        m_ph = 3; m_dwell = 0;
        m_settle = (settle_cycles == 0) ? 1 : int'(settle_cycles);
      end else if (m_win != 0 && m_dwell == m_win) begin
        m_retry++;
        m_run = 0;
        m_ph = (m_retry == MR) ? 5 : 1;
      end
    end else if (m_ph == 3) begin
      m_dwell++;
      if (m_dwell >= m_settle) m_ph = 4;
    end
  endfunction

  task automatic check_all();
    chk("state", 32'(ctrl_state), m_ph);
    chk("tx_online", 32'(tx_online), (m_ph >= 2 && m_ph <= 4) ? 1 : 0);
    chk("rx_online", 32'(rx_online), (m_ph == 3 || m_ph == 4) ? 1 : 0);
    chk("link_up", 32'(link_up), (m_ph == 4) ? 1 : 0);
    chk("timeout_err", 32'(timeout_err), (m_ph == 5) ? 1 : 0);
    chk("retry_cnt", 32'(retry_cnt), m_retry);
    chk("link_drop", 32'(link_drop), 32'(m_drop));
  endtask

  task automatic step(input bit en, input bit txr, input bit rxr,
                      input bit ad);
    enable = en; phy_tx_ready = txr; phy_rx_ready = rxr;
    align_done = ad;
    @(posedge clk_wr);
    m_step(en, txr & rxr, ad);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_wr_n = 1'b0;
    m_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk_wr);
    #1;
    check_all();
    rst_wr_n = 1'b1;
  endtask

  task automatic run_nominal(input int sc);
    step(0, 1, 1, 0);
    align_timeout = 16'd100;
    settle_cycles = 16'(sc);
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, 1, i == 16);
      if (i == 9)  chk("nom_tx9", 32'(tx_online), 0);
      if (i == 10) chk("nom_tx10", 32'(tx_online), 1);
      if (i == 15) chk("nom_rx15", 32'(rx_online), 0);
      if (i == 16) chk("nom_rx16", 32'(rx_online), 1);
      if (i == 19) chk("nom_up19", 32'(link_up), 0);
      if (i == 20) chk("nom_up20", 32'(link_up), 1);
    end
    chk("nom_retry", 32'(retry_cnt), 0);
  endtask

  initial begin
    int txc;
    rst_wr_n = 1'b0; enable = 0; phy_tx_ready = 0; phy_rx_ready = 0;
    align_done = 0; align_timeout = '0; settle_cycles = '0;
    m_reset();
    do_reset();

    run_nominal(4);

    // link loss from LINK_UP
    step(1, 0, 1, 1);
    chk("loss_drop", 32'(link_drop), 1);
    chk("loss_up", 32'(link_up), 0);
    step(1, 1, 1, 1);
    chk("loss_drop1", 32'(link_drop), 0);
    repeat (20) step(1, 1, 1, 1);
    chk("loss_reup", 32'(link_up), 1);
    chk("loss_retry", 32'(retry_cnt), 0);

    // timeout and retry exhaustion
    step(0, 1, 1, 0);
    align_timeout = 16'd20;
    txc = 0;
    for (int i = 0; i < 150; i++) begin
      step(1, 1, 1, 0);
      if (tx_online) txc++;
    end
    chk("to_txcyc", txc, 60);
    chk("to_state", 32'(ctrl_state), 5);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_retry", 32'(retry_cnt), 3);
    step(0, 1, 1, 0);
    chk("to_clr", 32'(timeout_err), 0);

    // align_done on the final timeout cycle
    align_timeout = 16'd5;
    for (int i = 1; i <= 15; i++) step(1, 1, 1, i == 15);
    chk("col_state", 32'(ctrl_state), 3);
    chk("col_retry", 32'(retry_cnt), 0);

    // debounce glitch at stable count 5
    step(0, 1, 1, 0);
    align_timeout = 16'd100;
    for (int i = 1; i <= 16; i++) begin
      step(1, 1, i != 7, 0);
      if (i == 15) chk("deb_tx15", 32'(tx_online), 0);
      if (i == 16) chk("deb_tx16", 32'(tx_online), 1);
    end

    // async reset in RX_ON
    step(0, 1, 1, 0);
    settle_cycles = 16'd50;
    for (int i = 1; i <= 17; i++) step(1, 1, 1, i == 16);
    chk("ar_pre", 32'(rx_online), 1);
    #3;
    rst_wr_n = 1'b0;
    m_reset();
    #1;
    check_all();
    @(posedge clk_wr);
    #1;
    check_all();
    rst_wr_n = 1'b1;
    run_nominal(4);

    // randomized episodes
    for (int e = 0; e < 30; e++) begin
      step(0, 1, 1, 0);
      align_timeout = 16'($urandom_range(0, 30));
      settle_cycles = 16'($urandom_range(0, 6));
      for (int c = 0; c < 200; c++) begin
        step($urandom_range(0, 79) != 0,
             $urandom_range(0, 24) != 0,
             $urandom_range(0, 24) != 0,
             $urandom_range(0, 7) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
